// File: rtl/adc_pattern_check_if.sv
// Sequencer/deserializer-side bundle for one ADC channel checker.
// The sequencer/deserializer side drives the master modport; the checker uses the slave modport.
interface adc_pattern_check_if #(
    parameter int WIDTH = 12
);
    logic             seq_reset;
    logic             seq_enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [31:0]      word_cnt;
    logic [15:0]      err_cnt;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output seq_reset, seq_enable, mode, din, din_valid,
        input  word_cnt, err_cnt, busy, done, pass
    );

    modport slave (
        input  seq_reset, seq_enable, mode, din, din_valid,
        output word_cnt, err_cnt, busy, done, pass
    );
endinterface

// File: rtl/adc_pattern_check.sv
// ADC test-pattern checker: counts words and mismatches inside the sequencer
// window and latches a pass/fail verdict when the window closes.
module adc_pattern_check #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] FIXED = 12'hA5C
) (
    input  logic                clk,
    input  logic                reset_n,
    adc_pattern_check_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARMED, SYNC, CHECK, DONE} state_t;

    state_t           state_q, state_nxt;
    logic             sr_q, en_q, vld_q;
    logic [1:0]       mode_in_q, mode_r, mode_nxt;
    logic [WIDTH-1:0] din_q, exp_q, exp_nxt;
    logic [31:0]      word_q, word_nxt;
    logic [15:0]      err_q, err_nxt;
    logic             done_q, done_nxt, pass_q, pass_nxt, busy_q;

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x,
                                                   input logic [1:0] m);
        case (m)
            2'd0:    next_word = x + 1'b1;
            2'd1:    next_word = ~x;
            default: next_word = FIXED;
        endcase
    endfunction

    // Input stage: every control decision works on these registered copies,
    // which is where the one-cycle count/verdict latency comes from.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= 1'b0;
            en_q      <= 1'b0;
            vld_q     <= 1'b0;
            mode_in_q <= '0;
            din_q     <= '0;
        end else begin
            sr_q      <= bus.seq_reset;
            en_q      <= bus.seq_enable;
            vld_q     <= bus.din_valid;
            mode_in_q <= bus.mode;
            din_q     <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_r  <= '0;
            exp_q   <= '0;
            word_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_r  <= mode_nxt;
            exp_q   <= exp_nxt;
            word_q  <= word_nxt;
            err_q   <= err_nxt;
            done_q  <= done_nxt;
            pass_q  <= pass_nxt;
            busy_q  <= (state_nxt == SYNC) || (state_nxt == CHECK);
        end
    end

    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_r;
        exp_nxt   = exp_q;
        word_nxt  = word_q;
        err_nxt   = err_q;
        done_nxt  = done_q;
        pass_nxt  = pass_q;
        if (sr_q) begin
            state_nxt = ARMED;
            mode_nxt  = mode_in_q;
            word_nxt  = '0;
            err_nxt   = '0;
            done_nxt  = 1'b0;
            pass_nxt  = 1'b0;
        end else begin
            case (state_q)
                ARMED: if (en_q) state_nxt = SYNC;
                SYNC: begin
                    if (!en_q) begin
                        // No word was ever checked, so the verdict is a fail.
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b0;
                    end else if (vld_q) begin
                        state_nxt = CHECK;
                        exp_nxt   = next_word(din_q, mode_r);
                        if (mode_r[1] && din_q != FIXED) err_nxt = err_q + 16'd1;
                    end
                end
                CHECK: begin
                    if (vld_q) begin
                        if (word_q != '1) word_nxt = word_q + 32'd1;
                        if (din_q != exp_q && err_q != '1) err_nxt = err_q + 16'd1;
                        exp_nxt = next_word(exp_q, mode_r);
                    end
                    // Verdict uses the post-update counts so a closing word is included.
                    if (!en_q) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == '0) && (word_nxt != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.word_cnt = word_q;
    assign bus.err_cnt  = err_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
endmodule

// File: tb/tb_adc_pattern_check.sv
// Directed bench for adc_pattern_check: pattern windows, saturation, and reset cases.
module tb_adc_pattern_check;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    adc_pattern_check_if #(.WIDTH(12)) bus ();

    adc_pattern_check #(.WIDTH(12), .FIXED(12'hA5C)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] m);
        bus.seq_reset = 1'b1;
        bus.mode      = m;
        step();
        bus.seq_reset = 1'b0;
        bus.mode      = ~m;
        step();
    endtask

    task automatic open_win(input string tag);
        int k;
        k = 0;
        bus.seq_enable = 1'b1;
        while (!bus.busy && k < 10) begin
            step();
            k++;
        end
        chk(tag, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic close_win();
        bus.din_valid  = 1'b0;
        bus.seq_enable = 1'b0;
        repeat (3) step();
    endtask

    task automatic send(input logic [11:0] d);
        bus.din       = d;
        bus.din_valid = 1'b1;
        step();
    endtask

    task automatic verdict(input string tag, input logic [31:0] w, input logic [15:0] e,
                           input logic d, input logic p);
        chk({tag, "_word"}, bus.word_cnt, w);
        chk({tag, "_err"},  {16'd0, bus.err_cnt}, {16'd0, e});
        chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, d});
        chk({tag, "_pass"}, {31'd0, bus.pass}, {31'd0, p});
    endtask

    initial begin
        logic [11:0] v;
        int nv;
        bus.seq_reset = 0; bus.seq_enable = 0; bus.mode = 0; bus.din = 0; bus.din_valid = 0;
        repeat (3) step();
        verdict("rst", 32'd0, 16'd0, 1'b0, 1'b0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset_n = 1'b1;
        step();

        // ramp clean, 1000 words wrapping through 12'hFFF
        arm(2'd0);
        open_win("ramp_busy");
        v = 12'hE80;
        for (int i = 0; i < 1000; i++) begin send(v); v = v + 12'd1; end
        chk("ramp_busy_hold", {31'd0, bus.busy}, 32'd1);
        close_win();
        verdict("ramp", 32'd999, 16'd0, 1'b1, 1'b1);
        chk("ramp_busy_fall", {31'd0, bus.busy}, 32'd0);

        // ramp single glitch at word 10
        arm(2'd0);
        open_win("glitch_busy");
        for (int i = 0; i < 1000; i++) send(i == 10 ? 12'h3FF : 12'(i));
        close_win();
        verdict("glitch", 32'd999, 16'd1, 1'b1, 1'b0);

        // ramp slip: word 10 dropped, checker never resyncs
        arm(2'd0);
        open_win("slip_busy");
        for (int i = 0; i < 1000; i++) if (i != 10) send(12'(i));
        close_win();
        verdict("slip", 32'd998, 16'd989, 1'b1, 1'b0);

        // toggle with valid low on every third cycle
        arm(2'd1);
        open_win("tog_busy");
        v = 12'hAAA;
        nv = 0;
        for (int c = 0; c < 300; c++) begin
            if (c % 3 == 2) begin
                bus.din_valid = 1'b0;
                bus.din = 12'h123;
                step();
            end else begin
                send(v);
                v = ~v;
                nv++;
            end
        end
        close_win();
        verdict("tog", 32'(nv - 1), 16'd0, 1'b1, 1'b1);

        // mode 3 behaves as fixed; last word coincides with enable falling
        arm(2'd3);
        open_win("fix3_busy");
        send(12'hA5C);
        send(12'hA5C);
        send(12'hA5C);
        bus.din = 12'hA5C;
        bus.din_valid = 1'b1;
        bus.seq_enable = 1'b0;
        step();
        bus.din_valid = 1'b0;
        repeat (3) step();
        verdict("fix3", 32'd3, 16'd0, 1'b1, 1'b1);

        // fixed mode, wrong constant data: error counter saturates
        arm(2'd2);
        open_win("sat_busy");
        for (int i = 0; i < 70000; i++) send(12'h000);
        close_win();
        verdict("sat", 32'd69999, 16'hFFFF, 1'b1, 1'b0);

        // empty window
        arm(2'd0);
        bus.seq_enable = 1'b1;
        repeat (5) step();
        close_win();
        verdict("empty", 32'd0, 16'd0, 1'b1, 1'b0);

        // async reset mid-check
        arm(2'd0);
        open_win("areset_busy");
        for (int i = 0; i < 20; i++) send(12'(i));
        #2 reset_n = 1'b0;
        #1;
        verdict("areset", 32'd0, 16'd0, 1'b0, 1'b0);
        chk("areset_busy0", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.din_valid = 1'b0;
        bus.seq_enable = 1'b0;
        step();
        bus.seq_enable = 1'b1;
        for (int i = 0; i < 10; i++) send(12'(i));
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        close_win();
        verdict("idle", 32'd0, 16'd0, 1'b0, 1'b0);

        // recovers once re-armed
        arm(2'd0);
        open_win("rearm_busy");
        for (int i = 0; i < 5; i++) send(12'(i + 7));
        close_win();
        verdict("rearm", 32'd4, 16'd0, 1'b1, 1'b1);

        // seq_reset during DONE overrides simultaneous enable and valid
        bus.seq_reset = 1'b1;
        bus.seq_enable = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 12'h000;
        step();
        bus.seq_reset = 1'b0;
        bus.seq_enable = 1'b0;
        bus.din_valid = 1'b0;
        step();
        verdict("sreset", 32'd0, 16'd0, 1'b0, 1'b0);
        chk("sreset_busy", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
